// File: rtl/fifo_param.sv
// Single-clock parameterised FIFO with registered read data and occupancy-derived status flags.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_FLAGS_EN is defined.
module fifo_param #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned ADDR_BITS    = 4,
    parameter int unsigned AFULL_LEVEL  = 12,
    parameter int unsigned AEMPTY_LEVEL = 4
) (
    input  logic                 clock_in,
    input  logic                 reset_in,
    input  logic                 write_in,
    input  logic [WIDTH-1:0]     wdata_in,
    input  logic                 read_in,
    output logic [WIDTH-1:0]     rdata_out,
    output logic                 empty_out,
    output logic                 full_out,
    output logic                 almost_empty_out,
    output logic                 almost_full_out,
    output logic [ADDR_BITS:0]   count_out
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic                 overflow_out,
    output logic                 underflow_out
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    localparam logic [ADDR_BITS:0]   DEPTH_CNT  = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS:0]   AFULL_CNT  = (ADDR_BITS + 1)'(AFULL_LEVEL);
    localparam logic [ADDR_BITS:0]   AEMPTY_CNT = (ADDR_BITS + 1)'(AEMPTY_LEVEL);
    localparam logic [ADDR_BITS:0]   CNT_ONE    = (ADDR_BITS + 1)'(1);
    localparam logic [ADDR_BITS-1:0] PTR_ONE    = ADDR_BITS'(1);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]   count_q, count_d;
    logic [WIDTH-1:0]     rdata_q, rdata_d;

    logic rd_accept;
    logic wr_accept;

    // A read frees a slot on the same edge, so a full FIFO can still take a write alongside it.
    assign rd_accept = read_in && (count_q != '0);
    assign wr_accept = write_in && ((count_q != DEPTH_CNT) || rd_accept);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rdata_d  = rdata_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            rdata_d  = mem[rd_ptr_q];
        end

        unique case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage is not reset; stale entries are unreachable once pointers and count are cleared.
    always_ff @(posedge clock_in) begin
        if (!reset_in && wr_accept) begin
            mem[wr_ptr_q] <= wdata_in;
        end
    end

    assign rdata_out        = rdata_q;
    assign count_out        = count_q;
    assign empty_out        = (count_q == '0);
    assign full_out         = (count_q == DEPTH_CNT);
    assign almost_empty_out = (count_q <= AEMPTY_CNT);
    assign almost_full_out  = (count_q >= AFULL_CNT);

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q | (write_in & ~wr_accept);
        underflow_d = underflow_q | (read_in & ~rd_accept);
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow_out  = overflow_q;
    assign underflow_out = underflow_q;
`endif

endmodule
